// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared types and default constants for the execution controller.
//   estado_t            - controller FSM state encoding (5 states, 3 bits)
//   DEBOUNCE_CYCLES_DEF - default stable-sample count for the button debouncer
//   INSTR_CNT_WIDTH_DEF - default width of the committed-instruction counter
//   DATA_WIDTH_DEF      - default width of the OUT display word
package ctrl_pkg;

    typedef enum logic [2:0] {
        EXECUTA      = 3'd0,
        ESPERA_IN    = 3'd1,
        ESPERA_PASSO = 3'd2,
        LIBERA       = 3'd3,
        PARADO       = 3'd4
    } estado_t;

    localparam int DEBOUNCE_CYCLES_DEF = 16;
    localparam int INSTR_CNT_WIDTH_DEF = 16;
    localparam int DATA_WIDTH_DEF      = 28;

endpackage

// File: rtl/debounce_botao.sv
// debounce_botao: 2-FF synchronizer, debounce counter and rising-edge pulse
// for a raw push-button.
// Ports:
//   clock       in  system clock, rising edge
//   reset       in  synchronous, active-high reset
//   botao       in  raw button, asynchronous to clock
//   botao_pulso out one-cycle pulse per accepted 0->1 transition
module debounce_botao
    import ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic botao,
    output logic botao_pulso
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic          sync1_q;
    logic          sync2_q;
    logic [CW-1:0] cnt_q;
    logic          nivel_q;
    logic          pulso_q;

    // cnt_q counts consecutive samples that disagree with the accepted level;
    // the level flips on the DEBOUNCE_CYCLES-th such sample.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            nivel_q <= 1'b0;
            pulso_q <= 1'b0;
        end else begin
            sync1_q <= botao;
            sync2_q <= sync1_q;
            pulso_q <= 1'b0;
            if (sync2_q == nivel_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                cnt_q   <= '0;
                nivel_q <= sync2_q;
                pulso_q <= sync2_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign botao_pulso = pulso_q;

endmodule

// File: rtl/controlador_execucao.sv
// controlador_execucao: gates the single-cycle CPU with a clock enable and
// services its IN / OUT / HALT opcodes.
// Optional feature: define CTRL_MODO_PASSO_EN to enable single-step mode;
// without it modo_passo is ignored and ESPERA_PASSO is not built.
// Ports:
//   clock, reset         system clock / synchronous active-high reset
//   botao                raw confirm/step push-button
//   modo_passo           single-step request (level)
//   OpIn, OpOut, OpHalt  decoded opcode flags of the current instruction
//   dado_saida           CPU display word
//   cpu_en               CPU clock enable (Mealy)
//   saida_reg            word latched by the last OUT
//   saida_valida         one-cycle pulse after saida_reg updates
//   esperando_entrada    waiting for IN confirmation
//   parado               halted
//   contador_instr       committed-instruction count (wraps)
//
// state        | meaning
// EXECUTA      | free run, cpu_en follows opcodes
// ESPERA_IN    | IN stalled until a button pulse
// ESPERA_PASSO | step mode, waiting for a button pulse
// LIBERA       | one enabled cycle to commit the stalled instruction
// PARADO       | halted until reset
module controlador_execucao
    import ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int DATA_WIDTH      = DATA_WIDTH_DEF,
    parameter int INSTR_CNT_WIDTH = INSTR_CNT_WIDTH_DEF
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       botao,
    input  logic                       modo_passo,
    input  logic                       OpIn,
    input  logic                       OpOut,
    input  logic                       OpHalt,
    input  logic [DATA_WIDTH-1:0]      dado_saida,
    output logic                       cpu_en,
    output logic [DATA_WIDTH-1:0]      saida_reg,
    output logic                       saida_valida,
    output logic                       esperando_entrada,
    output logic                       parado,
    output logic [INSTR_CNT_WIDTH-1:0] contador_instr
);

    estado_t                    estado_q, estado_d;
    logic                       botao_pulso;
    logic [DATA_WIDTH-1:0]      saida_q;
    logic                       valida_q;
    logic [INSTR_CNT_WIDTH-1:0] cnt_q;

    debounce_botao #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
        .clock      (clock),
        .reset      (reset),
        .botao      (botao),
        .botao_pulso(botao_pulso)
    );

`ifndef CTRL_MODO_PASSO_EN
    logic unused_modo_passo;
    assign unused_modo_passo = modo_passo;
`endif

    always_comb begin
        estado_d          = estado_q;
        cpu_en            = 1'b0;
        esperando_entrada = 1'b0;
        parado            = 1'b0;
        case (estado_q)
            EXECUTA: begin
                if (OpHalt)      estado_d = PARADO;
                else if (OpIn)   estado_d = ESPERA_IN;
`ifdef CTRL_MODO_PASSO_EN
                else if (modo_passo) estado_d = ESPERA_PASSO;
`endif
                else             cpu_en   = 1'b1;
            end
            ESPERA_IN: begin
                esperando_entrada = 1'b1;
                if (botao_pulso) estado_d = LIBERA;
            end
`ifdef CTRL_MODO_PASSO_EN
            ESPERA_PASSO: begin
                if (botao_pulso)      estado_d = LIBERA;
                else if (!modo_passo) estado_d = EXECUTA;
            end
`endif
            LIBERA: begin
                cpu_en   = 1'b1;
                estado_d = EXECUTA;
            end
            PARADO: begin
                parado = 1'b1;
            end
            default: estado_d = EXECUTA;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q <= EXECUTA;
            saida_q  <= '0;
            valida_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            estado_q <= estado_d;
            valida_q <= cpu_en & OpOut;
            if (cpu_en && OpOut) saida_q <= dado_saida;
            if (cpu_en)          cnt_q   <= cnt_q + 1'b1;
        end
    end

    assign saida_reg      = saida_q;
    assign saida_valida   = valida_q;
    assign contador_instr = cnt_q;

endmodule

// File: tb/tb_controlador_execucao.sv
module tb_controlador_execucao;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        botao = 1'b0;
    logic        modo_passo = 1'b0;
    logic        OpIn = 1'b0;
    logic        OpOut = 1'b0;
    logic        OpHalt = 1'b0;
    logic [27:0] dado_saida = '0;
    logic        cpu_en;
    logic [27:0] saida_reg;
    logic        saida_valida;
    logic        esperando_entrada;
    logic        parado;
    logic [15:0] contador_instr;

    int vectors = 0;
    int errors  = 0;

    controlador_execucao #(
        .DEBOUNCE_CYCLES(4),
        .DATA_WIDTH(28),
        .INSTR_CNT_WIDTH(16)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .botao            (botao),
        .modo_passo       (modo_passo),
        .OpIn             (OpIn),
        .OpOut            (OpOut),
        .OpHalt           (OpHalt),
        .dado_saida       (dado_saida),
        .cpu_en           (cpu_en),
        .saida_reg        (saida_reg),
        .saida_valida     (saida_valida),
        .esperando_entrada(esperando_entrada),
        .parado           (parado),
        .contador_instr   (contador_instr)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        botao = 0; modo_passo = 0; OpIn = 0; OpOut = 0; OpHalt = 0; dado_saida = '0;
        reset = 1;
        tick(); tick();
        reset = 0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (cpu_en !== 1'b1 || parado !== 1'b0 || esperando_entrada !== 1'b0) begin
            errors++; $display("FAIL reset_flags: cpu_en=%b parado=%b esp=%b, want 1 0 0", cpu_en, parado, esperando_entrada);
        end
        vectors++;
        if (saida_reg !== 28'h0 || saida_valida !== 1'b0 || contador_instr !== 16'd0) begin
            errors++; $display("FAIL reset_regs: saida=%h val=%b cnt=%0d, want 0 0 0", saida_reg, saida_valida, contador_instr);
        end
    endtask

    task automatic test_free_run();
        int low = 0;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            if (cpu_en !== 1'b1) low++;
            tick();
        end
        vectors++;
        if (low != 0) begin
            errors++; $display("FAIL free_run_en: %0d cycles with cpu_en low, want 0", low);
        end
        vectors++;
        if (contador_instr !== 16'd10) begin
            errors++; $display("FAIL free_run_cnt: got %0d, want 10", contador_instr);
        end
    endtask

    task automatic test_in_stall();
        int enables = 0;
        int first = -1;
        do_reset();
        OpIn = 1; #1;
        vectors++;
        if (cpu_en !== 1'b0 || esperando_entrada !== 1'b0) begin
            errors++; $display("FAIL in_mealy: cpu_en=%b esp=%b, want 0 0", cpu_en, esperando_entrada);
        end
        tick();
        vectors++;
        if (cpu_en !== 1'b0 || esperando_entrada !== 1'b1) begin
            errors++; $display("FAIL in_wait: cpu_en=%b esp=%b, want 0 1", cpu_en, esperando_entrada);
        end
        botao = 1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (k == 8) botao = 0;
            if (cpu_en === 1'b1) begin
                enables++;
                if (first < 0) first = k;
            end
        end
        vectors++;
        if (enables != 1 || first != 7) begin
            errors++; $display("FAIL in_release: enables=%0d at cycle %0d, want 1 at 7", enables, first);
        end
        vectors++;
        if (contador_instr !== 16'd1 || esperando_entrada !== 1'b1) begin
            errors++; $display("FAIL in_commit: cnt=%0d esp=%b, want 1 1", contador_instr, esperando_entrada);
        end
    endtask

    task automatic test_out_latch();
        do_reset();
        OpOut = 1; dado_saida = 28'h00ABCDE; #1;
        vectors++;
        if (cpu_en !== 1'b1) begin
            errors++; $display("FAIL out_en: cpu_en=%b, want 1", cpu_en);
        end
        tick();
        OpOut = 0; dado_saida = 28'h1234567; #1;
        vectors++;
        if (saida_reg !== 28'h00ABCDE || saida_valida !== 1'b1) begin
            errors++; $display("FAIL out_latch: saida=%h val=%b, want 00abcde 1", saida_reg, saida_valida);
        end
        tick();
        vectors++;
        if (saida_reg !== 28'h00ABCDE || saida_valida !== 1'b0) begin
            errors++; $display("FAIL out_hold: saida=%h val=%b, want 00abcde 0", saida_reg, saida_valida);
        end
        OpIn = 1; OpOut = 1; dado_saida = 28'h0000123;
        tick(); tick(); tick();
        vectors++;
        if (saida_reg !== 28'h00ABCDE || saida_valida !== 1'b0) begin
            errors++; $display("FAIL out_stall: saida=%h val=%b, want 00abcde 0", saida_reg, saida_valida);
        end
    endtask

    task automatic test_bounce();
        int enables = 0;
        do_reset();
        OpIn = 1;
        tick();
        for (int k = 0; k < 20; k++) begin
            botao = k[1];
            tick();
            if (cpu_en === 1'b1) enables++;
        end
        botao = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (cpu_en === 1'b1) enables++;
        end
        vectors++;
        if (enables != 0 || esperando_entrada !== 1'b1) begin
            errors++; $display("FAIL bounce: enables=%0d esp=%b, want 0 1", enables, esperando_entrada);
        end
    endtask

    task automatic test_pulse_discard();
        int enables = 0;
        do_reset();
        botao = 1;
        for (int k = 0; k < 10; k++) tick();
        botao = 0;
        for (int k = 0; k < 10; k++) tick();
        OpIn = 1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (cpu_en === 1'b1) enables++;
        end
        vectors++;
        if (enables != 0 || contador_instr !== 16'd20) begin
            errors++; $display("FAIL pulse_discard: enables=%0d cnt=%0d, want 0 20", enables, contador_instr);
        end
    endtask

    task automatic test_halt();
        int enables = 0;
        do_reset();
        OpHalt = 1; OpIn = 1; #1;
        vectors++;
        if (cpu_en !== 1'b0) begin
            errors++; $display("FAIL halt_mealy: cpu_en=%b, want 0", cpu_en);
        end
        tick();
        OpHalt = 0; OpIn = 0; #1;
        vectors++;
        if (parado !== 1'b1 || esperando_entrada !== 1'b0 || cpu_en !== 1'b0) begin
            errors++; $display("FAIL halt_state: parado=%b esp=%b en=%b, want 1 0 0", parado, esperando_entrada, cpu_en);
        end
        botao = 1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (cpu_en === 1'b1) enables++;
        end
        botao = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (cpu_en === 1'b1) enables++;
        end
        vectors++;
        if (enables != 0 || parado !== 1'b1) begin
            errors++; $display("FAIL halt_button: enables=%0d parado=%b, want 0 1", enables, parado);
        end
        reset = 1;
        tick();
        reset = 0; #1;
        vectors++;
        if (parado !== 1'b0 || cpu_en !== 1'b1 || contador_instr !== 16'd0) begin
            errors++; $display("FAIL halt_reset: parado=%b en=%b cnt=%0d, want 0 1 0", parado, cpu_en, contador_instr);
        end
    endtask

    task automatic test_step();
        int enables = 0;
        do_reset();
        modo_passo = 1; #1;
`ifdef CTRL_MODO_PASSO_EN
        vectors++;
        if (cpu_en !== 1'b0) begin
            errors++; $display("FAIL step_mealy: cpu_en=%b, want 0", cpu_en);
        end
        tick();
        for (int p = 0; p < 3; p++) begin
            botao = 1;
            for (int k = 0; k < 6; k++) begin
                tick();
                if (cpu_en === 1'b1) enables++;
            end
            botao = 0;
            for (int k = 0; k < 10; k++) begin
                tick();
                if (cpu_en === 1'b1) enables++;
            end
        end
        vectors++;
        if (enables != 3 || contador_instr !== 16'd3) begin
            errors++; $display("FAIL step_presses: enables=%0d cnt=%0d, want 3 3", enables, contador_instr);
        end
        modo_passo = 0; #1;
        vectors++;
        if (cpu_en !== 1'b0) begin
            errors++; $display("FAIL step_exit_hold: cpu_en=%b, want 0", cpu_en);
        end
        tick();
        vectors++;
        if (cpu_en !== 1'b1 || contador_instr !== 16'd3) begin
            errors++; $display("FAIL step_exit: cpu_en=%b cnt=%0d, want 1 3", cpu_en, contador_instr);
        end
`else
        for (int k = 0; k < 5; k++) begin
            if (cpu_en !== 1'b1) enables++;
            tick();
        end
        vectors++;
        if (enables != 0 || contador_instr !== 16'd5) begin
            errors++; $display("FAIL step_ignored: low=%0d cnt=%0d, want 0 5", enables, contador_instr);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_in_stall();
        test_out_latch();
        test_bounce();
        test_pulse_discard();
        test_halt();
        test_step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
